mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 26 ++
 rtl/mem_access_ctrl.sv | 122 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - pipeline/memory bus bundle for mem_access_ctrl
interface mem_access_ctrl_if;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] addr;
  logic [15:0] writeData;
  logic [15:0] mem_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        stall;
  logic        done;
  logic [15:0] mem_out;
  logic        err;

  modport slave (
    input  MemRead, MemWrite, addr, writeData, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, stall, done, mem_out, err
  );

  modport master (
    output MemRead, MemWrite, addr, writeData, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, stall, done, mem_out, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - multi-cycle load/store sequencer; optional MEM_ALIGN_CHECK_EN
module mem_access_ctrl #(
  parameter int LATENCY = 4
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] mem_out_q;
  logic        wr_q;
  logic        req;
  logic        fault;
  logic        mem_en_c;
  logic        mem_wr_c;
  logic        done_c;
  logic        stall_c;

  assign req = bus.MemRead | bus.MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;
  assign fault   = bus.addr[0];
  assign bus.err = err_q;
`else
  assign fault   = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.mem_en    = mem_en_c;
  assign bus.mem_wr    = mem_wr_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.stall     = stall_c;
  assign bus.done      = done_c;
  assign bus.mem_out   = mem_out_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and decoded outputs; stall follows the live request in IDLE
  always_comb begin
    state_nxt = state;
    mem_en_c  = 1'b0;
    mem_wr_c  = 1'b0;
    done_c    = 1'b0;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall_c   = 1'b1;
          state_nxt = fault ? DONE : BUSY;
        end
      end
      BUSY: begin
        mem_en_c = 1'b1;
        mem_wr_c = wr_q;
        stall_c  = 1'b1;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        // The request still present here belongs to the instruction completing now
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, hold counter and registered load result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      wr_q      <= 1'b0;
      mem_out_q <= 16'h0000;
`ifdef MEM_ALIGN_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (fault) begin
              mem_out_q <= 16'h0000;
`ifdef MEM_ALIGN_CHECK_EN
              err_q     <= 1'b1;
`endif
            end else begin
              addr_q  <= bus.addr;
              wdata_q <= bus.writeData;
              wr_q    <= bus.MemWrite;
              cnt     <= 4'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             mem_out_q <= wr_q ? 16'h0000 : bus.mem_rdata;
        end
        DONE: begin
`ifdef MEM_ALIGN_CHECK_EN
          err_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized bench for mem_access_ctrl with a schedule-based reference model
module tb_mem_access_ctrl;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: an access is a schedule relative to its acceptance cycle
  int          start = -1;
  bit          flt   = 1'b0;
  bit          valid = 1'b0;
  logic [15:0] m_addr  = 16'h0;
  logic [15:0] m_wdata = 16'h0;
  logic [15:0] m_out   = 16'h0;
  bit          m_wr    = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit rd, input bit wr, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] rdat, input bit r);
    int off;
    int dd;
    bit acc;
    bit busy;
    bit dn;
    @(posedge clk);
    #1;
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.addr      = a;
    bus.writeData = wd;
    bus.mem_rdata = rdat;
    rst           = r;
    @(negedge clk);
    acc = 1'b0;
    off = cyc - start;
    dd  = flt ? 1 : L + 1;
    if ((start < 0 || off > dd) && (rd || wr)) begin
      acc   = 1'b1;
      start = cyc;
      off   = 0;
`ifdef MEM_ALIGN_CHECK_EN
      flt = a[0];
`else
      flt = 1'b0;
`endif
      dd = flt ? 1 : L + 1;
    end
    busy = (start >= 0) && !flt && off >= 1 && off <= L;
    dn   = (start >= 0) && off == dd;
    if (valid) begin
      check("mem_en",    16'(bus.mem_en), 16'(busy));
      check("mem_wr",    16'(bus.mem_wr), 16'(busy && m_wr));
      check("stall",     16'(bus.stall),  16'(busy || acc));
      check("done",      16'(bus.done),   16'(dn));
      check("err",       16'(bus.err),    16'(dn && flt));
      check("mem_addr",  bus.mem_addr,  m_addr);
      check("mem_wdata", bus.mem_wdata, m_wdata);
      check("mem_out",   bus.mem_out,   m_out);
    end
    if (acc && !flt) begin
      m_addr  = a;
      m_wdata = wd;
      m_wr    = wr;
    end
    if (acc && flt) m_out = 16'h0000;
    if (start >= 0 && !flt && off == L) m_out = m_wr ? 16'h0000 : rdat;
    if (r) begin
      start   = -1;
      flt     = 1'b0;
      m_addr  = 16'h0;
      m_wdata = 16'h0;
      m_out   = 16'h0;
      m_wr    = 1'b0;
      valid   = 1'b1;
    end
    cyc++;
  endtask

  initial begin
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.addr      = 16'h0;
    bus.writeData = 16'h0;
    bus.mem_rdata = 16'h0;

    step(0, 0, 16'h0, 16'h0, 16'h0, 1);
    step(0, 0, 16'h0, 16'h0, 16'h0, 1);
    step(0, 0, 16'h0, 16'h0, 16'h0, 0);

    // Load held through completion
    for (int i = 0; i < L + 2; i++) step(1, 0, 16'h0010, 16'h0, 16'hBEEF, 0);
    step(0, 0, 16'h0, 16'h0, 16'h0, 0);
    // Store
    for (int i = 0; i < L + 2; i++) step(0, 1, 16'h0020, 16'h1234, 16'h5555, 0);
    step(0, 0, 16'h0, 16'h0, 16'h0, 0);
    // Read and write together
    for (int i = 0; i < L + 2; i++) step(1, 1, 16'h0030, 16'hA5A5, 16'h7777, 0);
    step(0, 0, 16'h0, 16'h0, 16'h0, 0);
    // Back-to-back requests held through DONE
    for (int i = 0; i < 2 * (L + 2); i++) step(1, 0, 16'h0040, 16'h0, 16'(16'h1000 + i), 0);
    step(0, 0, 16'h0, 16'h0, 16'h0, 0);
    // Reset in the second BUSY cycle, then a request right after release
    step(1, 0, 16'h0050, 16'h0, 16'hCAFE, 0);
    step(1, 0, 16'h0050, 16'h0, 16'hCAFE, 0);
    step(1, 0, 16'h0050, 16'h0, 16'hCAFE, 1);
    step(0, 0, 16'h0, 16'h0, 16'h0, 0);
    for (int i = 0; i < L + 2; i++) step(0, 1, 16'h0060, 16'h4321, 16'h0, 0);
    step(0, 0, 16'h0, 16'h0, 16'h0, 0);
    // Odd address
    for (int i = 0; i < L + 2; i++) step(1, 0, 16'h0011, 16'h0, 16'hD00D, 0);
    step(0, 0, 16'h0, 16'h0, 16'h0, 0);

    for (int i = 0; i < 2000; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if ($urandom_range(3) != 0) a[0] = 1'b0;
      step($urandom_range(2) == 0, $urandom_range(3) == 0, a, 16'($urandom),
           16'($urandom), $urandom_range(59) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
